// File: rtl/pcs_pkg.sv
// Shared types and helpers for the point cloud stream packer: point layout,
// derived widths, point packing and the beat-assembly state encoding.
package pcs_pkg;

    localparam int DEF_COORD_W = 32;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_POINT_W = 3 * DEF_COORD_W + 4 * DEF_COLOR_W;

    function automatic int point_w(input int coord_w, input int color_w);
        return 3 * coord_w + 4 * color_w;
    endfunction

    function automatic int beat_w(input int coord_w, input int color_w, input int points);
        return points * point_w(coord_w, color_w);
    endfunction

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_COORD_W-1:0] z;
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
        logic [DEF_COLOR_W-1:0] intensity;
    } point_t;

    // MSB->LSB order is x, y, z, R, G, B, intensity
    function automatic logic [DEF_POINT_W-1:0] pack_point(input point_t p);
        return {p.x, p.y, p.z, p.r, p.g, p.b, p.intensity};
    endfunction

    typedef enum logic {
        EMPTY,
        FILLING
    } asm_state_t;

endpackage

// File: rtl/point_cloud_stream_packer_if.sv
// Point-in / beat-out handshake bundle. master = upstream decoder and
// downstream consumer side, slave = the packer itself.
interface point_cloud_stream_packer_if #(
    parameter int COORD_W         = 32,
    parameter int COLOR_W         = 8,
    parameter int POINTS_PER_BEAT = 4
);
    localparam int BEAT_W = pcs_pkg::beat_w(COORD_W, COLOR_W, POINTS_PER_BEAT);

    logic                       in_valid;
    logic                       in_ready;
    logic [COORD_W-1:0]         x;
    logic [COORD_W-1:0]         y;
    logic [COORD_W-1:0]         z;
    logic [COLOR_W-1:0]         R;
    logic [COLOR_W-1:0]         G;
    logic [COLOR_W-1:0]         B;
    logic [COLOR_W-1:0]         intensity;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [BEAT_W-1:0]          out_data;
    logic [POINTS_PER_BEAT-1:0] out_keep;
    logic                       out_last;

    modport master (
        output in_valid, x, y, z, R, G, B, intensity, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, x, y, z, R, G, B, intensity, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

endinterface

// File: rtl/pcs_beat_fifo.sv
// Beat FIFO of {keep, last, data} with a registered head: count includes the
// beat currently presented on the outputs, so DEPTH beats in total.
module pcs_beat_fifo #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [KEEP_W-1:0] push_keep,
    input  logic              push_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = KEEP_W + 1 + DATA_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [ENTRY_W-1:0] head_reg, head_next, push_entry;
    logic               out_valid_reg, pop;

    assign push_entry  = {push_keep, push_last, push_data};
    assign pop         = out_valid_reg && out_ready;
    assign count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

    // Head reloads only when it is free or being consumed; a beat pushed into
    // an otherwise empty store bypasses the array.
    always_comb begin
        head_next = head_reg;
        if (pop || !out_valid_reg) begin
            if (count_next == '0)
                head_next = '0;
            else if ((count_reg - CNT_W'(pop)) == '0)
                head_next = push_entry;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            head_reg      <= head_next;
            out_valid_reg <= (count_next != '0);
        end
    end

    assign {out_keep, out_last, out_data} = head_reg;
    assign out_valid = out_valid_reg;
    assign count     = count_reg;

endmodule

// File: rtl/point_cloud_stream_packer.sv
// Packs LiDAR points into POINTS_PER_BEAT-lane beats with keep/last.
// Optional macro PCS_ZERO_FILTER_EN drops x==y==z==0 points (last still honoured).
module point_cloud_stream_packer
    import pcs_pkg::*;
#(
    parameter int COORD_W         = 32,
    parameter int COLOR_W         = 8,
    parameter int POINTS_PER_BEAT = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input logic clk,
    input logic reset,
    point_cloud_stream_packer_if.slave bus
);
    localparam int POINT_W = point_w(COORD_W, COLOR_W);
    localparam int BEAT_W  = beat_w(COORD_W, COLOR_W, POINTS_PER_BEAT);
    localparam int LANE_W  = $clog2(POINTS_PER_BEAT + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    asm_state_t                 state_reg, state_next;
    logic [LANE_W-1:0]          lane_reg, lane_next;
    logic [BEAT_W-1:0]          asm_data_reg, asm_data_next, merged_data;
    logic [POINTS_PER_BEAT-1:0] asm_keep_reg, asm_keep_next, merged_keep;
    logic [POINT_W-1:0]         point_word;
    logic [CNT_W-1:0]           fifo_count;
    logic                       ready_en_reg, in_ready_int;
    logic                       accept, is_blank, write_pt, close;

    generate
        if (COORD_W == DEF_COORD_W && COLOR_W == DEF_COLOR_W) begin : g_std_point
            assign point_word = pack_point('{x: bus.x, y: bus.y, z: bus.z, r: bus.R,
                                             g: bus.G, b: bus.B, intensity: bus.intensity});
        end else begin : g_custom_point
            assign point_word = {bus.x, bus.y, bus.z, bus.R, bus.G, bus.B, bus.intensity};
        end
    endgenerate

`ifdef PCS_ZERO_FILTER_EN
    assign is_blank = (bus.x == '0) && (bus.y == '0) && (bus.z == '0);
`else
    assign is_blank = 1'b0;
`endif

    // Ready depends only on registered state: never on out_ready
    assign in_ready_int = ready_en_reg && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign bus.in_ready = in_ready_int;
    assign accept       = bus.in_valid && in_ready_int;
    assign write_pt     = accept && !is_blank;
    assign close        = accept && (bus.in_last ||
                          (write_pt && lane_reg == LANE_W'(POINTS_PER_BEAT - 1)));

    // Assembly register with the incoming point dropped into the current lane
    for (genvar gi = 0; gi < POINTS_PER_BEAT; gi++) begin : g_lane
        logic lane_hit;
        assign lane_hit = write_pt && (lane_reg == LANE_W'(gi));
        assign merged_data[gi*POINT_W +: POINT_W] =
            lane_hit ? point_word : asm_data_reg[gi*POINT_W +: POINT_W];
        assign merged_keep[gi] = lane_hit | asm_keep_reg[gi];
    end

    always_comb begin
        state_next    = state_reg;
        lane_next     = lane_reg;
        asm_data_next = asm_data_reg;
        asm_keep_next = asm_keep_reg;
        if (close) begin
            state_next    = EMPTY;
            lane_next     = '0;
            asm_data_next = '0;
            asm_keep_next = '0;
        end else if (write_pt) begin
            state_next    = FILLING;
            lane_next     = lane_reg + LANE_W'(1);
            asm_data_next = merged_data;
            asm_keep_next = merged_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            lane_reg     <= '0;
            asm_data_reg <= '0;
            asm_keep_reg <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lane_reg     <= lane_next;
            asm_data_reg <= asm_data_next;
            asm_keep_reg <= asm_keep_next;
            ready_en_reg <= 1'b1;
        end
    end

    pcs_beat_fifo #(
        .DATA_W (BEAT_W),
        .KEEP_W (POINTS_PER_BEAT),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (close),
        .push_data (merged_data),
        .push_keep (merged_keep),
        .push_last (bus.in_last),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_keep  (bus.out_keep),
        .out_last  (bus.out_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_point_cloud_stream_packer.sv
// Directed bench for point_cloud_stream_packer: a point-queue model predicts
// beats, ready and valid every cycle; a literal table pins each delivered beat.
module tb_point_cloud_stream_packer;

    localparam int N       = 4;
    localparam int DEPTH   = 4;
    localparam int POINT_W = 128;
    localparam int BEAT_W  = 512;
    localparam int NLIT    = 16;
`ifdef PCS_ZERO_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef struct {
        logic [BEAT_W-1:0] data;
        logic [N-1:0]      keep;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic done = 1'b0;

    always #5 clk = ~clk;

    point_cloud_stream_packer_if #(.COORD_W(32), .COLOR_W(8), .POINTS_PER_BEAT(N)) bus ();

    point_cloud_stream_packer #(
        .COORD_W         (32),
        .COLOR_W         (8),
        .POINTS_PER_BEAT (N),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hand-computed beats in delivery order: keep, last, lane0.x, lane3.x
    logic [3:0]  lit_keep [NLIT] = '{4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                     4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
`ifdef PCS_ZERO_FILTER_EN
                                     4'h1, 4'h0};
`else
                                     4'h7, 4'h1};
`endif
    logic        lit_last [NLIT] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [31:0] lit_x0   [NLIT] = '{1, 11, 15, 21, 25, 29, 33, 37, 41, 45, 49, 53, 57, 71,
`ifdef PCS_ZERO_FILTER_EN
                                     5, 0};
`else
                                     0, 0};
`endif
    logic [31:0] lit_x3   [NLIT] = '{4, 14, 0, 24, 28, 32, 36, 40, 44, 48, 52, 56, 60, 74, 0, 0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model + compare ----------------
    beat_t              q[$];
    logic [POINT_W-1:0] pend[$];
    bit                 started  = 1'b0;
    bit                 prev_rst = 1'b0;
    int                 pop_idx  = 0;
    int                 cycles   = 0;

    task automatic emit(input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < pend.size(); i++)
            b.data[i*POINT_W +: POINT_W] = pend[i];
        b.keep = N'((1 << pend.size()) - 1);
        b.last = last;
        q.push_back(b);
        pend.delete();
    endtask

    always @(negedge clk) begin
        cycles++;
        if (cycles > 5000) begin
            $display("FAIL watchdog: got %0d cycles expected under 5000", cycles);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
            $fatal(1, "watchdog");
        end
        if (started) begin
            if (prev_rst) begin
                chk("reset_out_valid", BEAT_W'(bus.out_valid), '0);
                chk("reset_out_data", bus.out_data, '0);
                chk("reset_out_keep", BEAT_W'(bus.out_keep), '0);
                chk("reset_out_last", BEAT_W'(bus.out_last), '0);
            end
            chk("in_ready", BEAT_W'(bus.in_ready), BEAT_W'(!prev_rst && q.size() < DEPTH));
            chk("out_valid", BEAT_W'(bus.out_valid), BEAT_W'(q.size() != 0));
            if (bus.out_valid && q.size() != 0) begin
                chk("out_data", bus.out_data, q[0].data);
                chk("out_keep", BEAT_W'(bus.out_keep), BEAT_W'(q[0].keep));
                chk("out_last", BEAT_W'(bus.out_last), BEAT_W'(q[0].last));
                if (bus.out_ready) begin
                    $display("beat %0d keep=%b last=%b x0=%0d x3=%0d", pop_idx, bus.out_keep,
                             bus.out_last, bus.out_data[96 +: 32], bus.out_data[480 +: 32]);
                    if (pop_idx < NLIT) begin
                        chk("lit_keep", BEAT_W'(bus.out_keep), BEAT_W'(lit_keep[pop_idx]));
                        chk("lit_last", BEAT_W'(bus.out_last), BEAT_W'(lit_last[pop_idx]));
                        chk("lit_x0", BEAT_W'(bus.out_data[96 +: 32]), BEAT_W'(lit_x0[pop_idx]));
                        chk("lit_x3", BEAT_W'(bus.out_data[480 +: 32]), BEAT_W'(lit_x3[pop_idx]));
                    end
                    pop_idx++;
                end
            end
        end
        if (reset) begin
            started = 1'b1;
            q.delete();
            pend.delete();
        end else if (started) begin
            if (bus.out_valid && bus.out_ready && q.size() != 0)
                q.delete(0);
            if (bus.in_valid && bus.in_ready) begin
                if (!(FILTER && bus.x == 0 && bus.y == 0 && bus.z == 0))
                    pend.push_back({bus.x, bus.y, bus.z, bus.R, bus.G, bus.B, bus.intensity});
                if (pend.size() == N || bus.in_last)
                    emit(bus.in_last);
            end
        end
        prev_rst = reset;
        if (done) begin
            chk("beats_delivered", BEAT_W'(pop_idx), BEAT_W'(NLIT));
            chk("queue_drained", BEAT_W'(q.size()), '0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] xv, input logic [31:0] yv,
                        input logic [31:0] zv, input logic last);
        bus.in_valid  = 1'b1;
        bus.x         = xv;
        bus.y         = yv;
        bus.z         = zv;
        bus.R         = xv[7:0] ^ 8'h5A;
        bus.G         = xv[7:0] + 8'd1;
        bus.B         = 8'hC3;
        bus.intensity = xv[7:0];
        bus.in_last   = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.z         = '0;
        bus.R         = '0;
        bus.G         = '0;
        bus.B         = '0;
        bus.intensity = '0;
        bus.out_ready = 1'b1;
        gap(3);
        reset = 1'b0;
        gap(3);

        // single full frame-closing beat
        for (int i = 1; i <= 4; i++) send(i, i + 1000, i + 2000, i == 4);
        gap(5);

        // full beat then partial closing beat
        for (int i = 11; i <= 16; i++) send(i, i + 1000, i + 2000, i == 16);
        gap(5);

        // backpressure: FIFO fills after 16 points
        bus.out_ready = 1'b0;
        fork
            for (int i = 21; i <= 40; i++) send(i, i + 1000, i + 2000, i == 40);
            begin gap(30); bus.out_ready = 1'b1; end
        join
        gap(10);

        // full FIFO drained while more beats are pushed
        bus.out_ready = 1'b0;
        for (int i = 41; i <= 56; i++) send(i, i + 1000, i + 2000, 1'b0);
        fork
            for (int i = 57; i <= 60; i++) send(i, i + 1000, i + 2000, i == 60);
            begin gap(1); bus.out_ready = 1'b1; end
        join
        gap(10);

        // reset with two beats queued and a half-built beat
        bus.out_ready = 1'b0;
        for (int i = 61; i <= 70; i++) send(i, i + 1000, i + 2000, 1'b0);
        reset = 1'b1;
        gap(2);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 71; i <= 74; i++) send(i, i + 1000, i + 2000, i == 74);
        gap(5);

        // blank points, then a lone blank point carrying last
        send(0, 0, 0, 1'b0);
        send(5, 5, 5, 1'b0);
        send(0, 0, 0, 1'b1);
        send(0, 0, 0, 1'b1);
        gap(10);
        done = 1'b1;
    end

endmodule
